// File: rtl/multi_edge_detector.sv
`default_nettype none
// ============================================================================
//  Module      : multi_edge_detector
//  Description : Multi-channel edge detector for asynchronous or noisy
//                single-bit inputs. Each channel is synchronised, debounced
//                and edge-decoded according to its own mode. Every channel
//                produces a one-cycle pulse and a write-1-to-clear sticky
//                flag. All channels feed one shared saturating event counter.
//  Ports       :
//    clk      in   1          rising-edge clock
//    reset    in   1          synchronous reset, active low (0 = reset)
//    din      in   WIDTH      raw asynchronous channel inputs
//    mode     in   2*WIDTH    mode[2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//    clear    in   WIDTH      write-1-to-clear for sticky[i]
//    cnt_clr  in   1          clears evt_cnt (events in the same cycle still count)
//    level    out  WIDTH      debounced, synchronised level per channel
//    pulse    out  WIDTH      one-cycle pulse per detected, enabled edge
//    sticky   out  WIDTH      latched event flags
//    any_evt  out  1          registered OR of the events behind pulse
//    evt_cnt  out  CNT_W      saturating total of detected events
//  Revision    : 1.0  initial release
// ============================================================================
module multi_edge_detector #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     din,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     clear,
    input  logic                 cnt_clr,
    output logic [WIDTH-1:0]     level,
    output logic [WIDTH-1:0]     pulse,
    output logic [WIDTH-1:0]     sticky,
    output logic                 any_evt,
    output logic [CNT_W-1:0]     evt_cnt
);

    // Debounce counter only needs to reach DEB_CYCLES-1; keep at least 1 bit.
    localparam int c_DCNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int c_POP_W  = $clog2(WIDTH + 1);
    localparam int c_SUM_W  = CNT_W + c_POP_W;

    localparam logic [c_DCNT_W-1:0] c_DCNT_LAST = c_DCNT_W'(DEB_CYCLES - 1);
    localparam logic [c_SUM_W-1:0]  c_SAT       = {{c_POP_W{1'b0}}, {CNT_W{1'b1}}};

    // ------------------------------------------------------------------
    // Synchroniser chain; stage SYNC_STAGES-1 is the usable sample.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_s;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Per-channel debounce and edge decode
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] w_level_nxt;
    logic [WIDTH-1:0] w_ev;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [c_DCNT_W-1:0] r_dcnt;
        logic                w_diff;
        logic                w_upd;

        assign w_diff = w_s[i] ^ r_level[i];
        // Level is accepted on the DEB_CYCLES-th consecutive mismatching edge.
        assign w_upd  = w_diff && (r_dcnt == c_DCNT_LAST);

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_dcnt <= '0;
            end else if (!w_diff || w_upd) begin
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + 1'b1;
            end
        end

        assign w_level_nxt[i] = w_upd ? w_s[i] : r_level[i];

        // On an update the new level is w_s, so w_s==1 means a rising edge.
        assign w_ev[i] = w_upd & ((w_s[i] & mode[2*i]) | (~w_s[i] & mode[2*i+1]));
    end

    // ------------------------------------------------------------------
    // Shared saturating event counter
    // ------------------------------------------------------------------
    logic [c_POP_W-1:0] w_pop;
    logic [c_SUM_W-1:0] w_base;
    logic [c_SUM_W-1:0] w_sum;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   r_cnt;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + c_POP_W'(w_ev[i]);
        end
    end

    // Sum is widened so adding up to WIDTH events can never wrap.
    assign w_base    = cnt_clr ? '0 : {{c_POP_W{1'b0}}, r_cnt};
    assign w_sum     = w_base + {{CNT_W{1'b0}}, w_pop};
    assign w_cnt_nxt = (w_sum > c_SAT) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_pulse;
    logic [WIDTH-1:0] r_sticky;
    logic             r_any;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_level  <= '0;
            r_pulse  <= '0;
            r_sticky <= '0;
            r_any    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_level  <= w_level_nxt;
            r_pulse  <= w_ev;
            // A new event beats a simultaneous clear so nothing is lost.
            r_sticky <= w_ev | (r_sticky & ~clear);
            r_any    <= |w_ev;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign level   = r_level;
    assign pulse   = r_pulse;
    assign sticky  = r_sticky;
    assign any_evt = r_any;
    assign evt_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multi_edge_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_edge_detector
//  Description : Directed self-checking bench for multi_edge_detector.
//                Main instance uses default parameters; a second instance
//                with CNT_W=3 exercises counter saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multi_edge_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din;
    logic [7:0] mode;
    logic [3:0] clear;
    logic       cnt_clr;
    logic [3:0] level, pulse, sticky;
    logic       any_evt;
    logic [7:0] evt_cnt;

    logic [3:0] din2;
    logic [7:0] mode2;
    logic [3:0] clear2;
    logic       cnt_clr2;
    logic [3:0] level2, pulse2, sticky2;
    logic       any_evt2;
    logic [2:0] evt_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_edge_detector dut (
        .clk     (clk),
        .reset   (reset),
        .din     (din),
        .mode    (mode),
        .clear   (clear),
        .cnt_clr (cnt_clr),
        .level   (level),
        .pulse   (pulse),
        .sticky  (sticky),
        .any_evt (any_evt),
        .evt_cnt (evt_cnt)
    );

    multi_edge_detector #(.CNT_W(3)) dut_sat (
        .clk     (clk),
        .reset   (reset),
        .din     (din2),
        .mode    (mode2),
        .clear   (clear2),
        .cnt_clr (cnt_clr2),
        .level   (level2),
        .pulse   (pulse2),
        .sticky  (sticky2),
        .any_evt (any_evt2),
        .evt_cnt (evt_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [3:0] acc;
    int         cnt_p;

    initial begin
        reset = 1'b0; din = 4'b0001; mode = 8'b01010101; clear = '0; cnt_clr = 1'b0;
        din2 = '0; mode2 = 8'hFF; clear2 = '0; cnt_clr2 = 1'b0;

        // ---- 1. din[0] held through reset release ----
        tick(3);
        check("rst_level",  level,   0);
        check("rst_pulse",  pulse,   0);
        check("rst_sticky", sticky,  0);
        check("rst_any",    any_evt, 0);
        check("rst_cnt",    evt_cnt, 0);
        reset = 1'b1;
        tick(5);
        check("t1_e5_level", level, 4'b0000);
        check("t1_e5_pulse", pulse, 4'b0000);
        tick(1);
        check("t1_e6_level",  level,   4'b0001);
        check("t1_e6_pulse",  pulse,   4'b0001);
        check("t1_e6_sticky", sticky,  4'b0001);
        check("t1_e6_any",    any_evt, 1);
        check("t1_e6_cnt",    evt_cnt, 1);
        tick(1);
        check("t1_e7_pulse", pulse,   4'b0000);
        check("t1_e7_any",   any_evt, 0);

        // ---- 2. debounce: 3-cycle glitch rejected, 4+ accepted ----
        din = 4'b0011;
        tick(3);
        din = 4'b0001;
        acc = '0;
        for (int j = 0; j < 8; j++) begin
            tick(1);
            acc = acc | pulse;
        end
        check("t2_glitch_pulse", acc, 4'b0000);
        check("t2_glitch_level", level, 4'b0001);
        din = 4'b0011;
        tick(5);
        check("t2_e5_pulse", pulse, 4'b0000);
        tick(1);
        check("t2_e6_pulse", pulse,  4'b0010);
        check("t2_e6_level", level,  4'b0011);
        check("t2_sticky",   sticky, 4'b0011);
        check("t2_cnt",      evt_cnt, 2);
        tick(1);
        check("t2_e7_pulse", pulse, 4'b0000);

        // ---- 3. fall-only on ch2, both on ch3 ----
        mode = 8'b01100101;
        cnt_p = 0;
        din = 4'b0111;
        for (int j = 0; j < 10; j++) begin tick(1); cnt_p += int'(pulse[2]); end
        check("t3_ch2_rise_pulses", cnt_p, 0);
        check("t3_ch2_level_hi", level, 4'b0111);
        din = 4'b0011;
        for (int j = 0; j < 10; j++) begin tick(1); cnt_p += int'(pulse[2]); end
        check("t3_ch2_pulses", cnt_p, 1);
        check("t3_ch2_cnt", evt_cnt, 3);
        mode = 8'b11100101;
        cnt_p = 0;
        din = 4'b1011;
        for (int j = 0; j < 10; j++) begin tick(1); cnt_p += int'(pulse[3]); end
        din = 4'b0011;
        for (int j = 0; j < 10; j++) begin tick(1); cnt_p += int'(pulse[3]); end
        check("t3_ch3_pulses", cnt_p, 2);
        check("t3_cnt",    evt_cnt, 5);
        check("t3_sticky", sticky,  4'b1111);

        // ---- 4. all channels at once, clear vs. set ----
        mode = 8'b01010101;
        din = 4'b0000;
        clear = 4'hF;
        tick(1);
        clear = 4'h0;
        check("t4_clear_all", sticky, 4'b0000);
        tick(8);
        check("t4_fall_level", level,   4'b0000);
        check("t4_fall_nocnt", evt_cnt, 5);
        check("t4_fall_nostk", sticky,  4'b0000);
        din = 4'hF;
        tick(5);
        check("t4_e5_pulse", pulse, 4'h0);
        tick(1);
        check("t4_e6_pulse", pulse,   4'hF);
        check("t4_e6_any",   any_evt, 1);
        check("t4_e6_cnt",   evt_cnt, 9);
        tick(1);
        check("t4_e7_pulse", pulse, 4'h0);
        din = 4'h0;
        clear = 4'hF;
        tick(1);
        clear = 4'h0;
        tick(8);
        check("t4_sticky_cleared", sticky, 4'h0);
        din = 4'h1;
        tick(5);
        clear = 4'h1;
        tick(1);
        check("t4_setclr_pulse",  pulse,   4'h1);
        check("t4_setclr_sticky", sticky,  4'h1);
        check("t4_setclr_cnt",    evt_cnt, 10);
        tick(1);
        check("t4_clr_only", sticky, 4'h0);
        clear = 4'h0;
        // mode 00 on ch1: level follows, no event
        mode = 8'b01010001;
        din = 4'b0011;
        acc = '0;
        for (int j = 0; j < 8; j++) begin tick(1); acc = acc | pulse; end
        check("t4_off_level",  level,   4'b0011);
        check("t4_off_pulse",  acc,     4'b0000);
        check("t4_off_sticky", sticky,  4'b0000);
        check("t4_off_cnt",    evt_cnt, 10);

        // ---- 5. saturation on the CNT_W=3 instance ----
        for (int e = 1; e <= 9; e++) begin
            din2[0] = ~din2[0];
            tick(8);
            if (e == 3) check("t5_cnt3", evt_cnt2, 3);
            if (e == 7) check("t5_cnt7", evt_cnt2, 7);
            if (e == 8) check("t5_cnt8_sat", evt_cnt2, 7);
        end
        check("t5_cnt9_sat", evt_cnt2, 7);
        din2[0] = ~din2[0];
        tick(5);
        cnt_clr2 = 1'b1;
        tick(1);
        check("t5_clr_evt_pulse", pulse2, 4'h1);
        check("t5_clr_evt_cnt", evt_cnt2, 1);
        tick(1);
        check("t5_clr_alone", evt_cnt2, 0);
        cnt_clr2 = 1'b0;

        // ---- 6. reset pulse mid-debounce ----
        mode = 8'hFF;
        din = 4'b0000;
        tick(8);
        check("t6_pre_cnt",    evt_cnt, 12);
        check("t6_pre_sticky", sticky,  4'b0011);
        mode = 8'b01010101;
        din = 4'b0001;
        tick(2);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check("t6_rst_level",  level,   0);
        check("t6_rst_pulse",  pulse,   0);
        check("t6_rst_sticky", sticky,  0);
        check("t6_rst_any",    any_evt, 0);
        check("t6_rst_cnt",    evt_cnt, 0);
        acc = '0;
        for (int j = 0; j < 5; j++) begin tick(1); acc = acc | pulse | level; end
        check("t6_no_early", acc, 4'b0000);
        tick(1);
        check("t6_e6_pulse",  pulse,   4'b0001);
        check("t6_e6_level",  level,   4'b0001);
        check("t6_e6_cnt",    evt_cnt, 1);
        check("t6_e6_sticky", sticky,  4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
